// File: rtl/mux_arbiter2_if.sv
// Request/grant bundle between two requesters and the shared mux arbiter.
//
// Handshake: reqX is a level request held by requester X for as long as it
// wants the mux; gntX is the registered answer (at most one grant is high).
// A requester owns the mux in every cycle its grant is high.
// y and y_valid are registered views of the granted data. y_valid=1 means y
// holds data that was both granted and requested in the sampled cycle.
interface mux_arbiter2_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic [WIDTH-1:0] a;
    logic             req1;
    logic [WIDTH-1:0] b;
    logic             gnt0;
    logic             gnt1;
    logic             s;
    logic [WIDTH-1:0] y;
    logic             y_valid;

    // Requester side: drives requests and data, observes grants and result.
    modport master (
        output req0, a, req1, b,
        input  gnt0, gnt1, s, y, y_valid
    );

    // Arbiter side: samples requests and data, drives grants and result.
    modport slave (
        input  req0, a, req1, b,
        output gnt0, gnt1, s, y, y_valid
    );
endinterface

// File: rtl/mux_arbiter2.sv
// Two-requester arbiter in front of a shared registered 2:1 mux.
// The FSM has three states: IDLE, GNT0 and GNT1. Ties from IDLE go to the
// requester that was not served last. A grant is released when its request
// drops, and it is handed straight to the other requester if that one waits.
// Optional hold limit: define MUX_ARB_HOLD_LIMIT_EN to force a handover
// after MAX_HOLD consecutive grant cycles while the other requester waits.
// state_dbg and hold_dbg expose internal state for observation.
module mux_arbiter2 #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    mux_arbiter2_if.slave               bus,
    output logic [1:0]                  state_dbg,
    output logic [$clog2(MAX_HOLD)-1:0] hold_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_e;

    state_e           state_q, state_d;
    logic             last_served_q, last_served_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             s_q, s_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic             grant_entry;
    logic             hold_expired;

`ifdef MUX_ARB_HOLD_LIMIT_EN
    localparam int HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    logic [HW-1:0] hold_q, hold_d;

    // The current owner has used up its share once the counter sits at the top.
    assign hold_expired = (hold_q == HOLD_LAST);

    // Count cycles a grant is kept: clear on entry, saturate at the limit.
    always_comb begin
        hold_d = hold_q;
        if (grant_entry || state_d == IDLE) begin
            hold_d = '0;
        end else if (hold_q != HOLD_LAST) begin
            hold_d = hold_q + 1'b1;
        end
    end
`else
    // No hold limit: a grant lasts until its own request drops.
    assign hold_expired = 1'b0;
`endif

    // Next-state decision from the current owner and both requests.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    state_d = last_served_q ? GNT0 : GNT1;
                end else if (bus.req0) begin
                    state_d = GNT0;
                end else if (bus.req1) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!bus.req0) begin
                    state_d = bus.req1 ? GNT1 : IDLE;
                end else if (hold_expired && bus.req1) begin
                    state_d = GNT1;
                end
            end
            GNT1: begin
                if (!bus.req1) begin
                    state_d = bus.req0 ? GNT0 : IDLE;
                end else if (hold_expired && bus.req0) begin
                    state_d = GNT0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Entry into a grant state: either from IDLE or a direct handover.
    assign grant_entry = (state_d != state_q) && (state_d != IDLE);

    // Registered outputs and fairness bookkeeping derived from the next state.
    always_comb begin
        last_served_d = last_served_q;
        if (grant_entry) begin
            last_served_d = (state_d == GNT1);
        end

        s_d = s_q;
        if (state_d == GNT0) begin
            s_d = 1'b0;
        end else if (state_d == GNT1) begin
            s_d = 1'b1;
        end

        gnt0_d    = (state_d == GNT0);
        gnt1_d    = (state_d == GNT1);
        y_d       = s_d ? bus.b : bus.a;
        y_valid_d = ((state_d == GNT0) && bus.req0) ||
                    ((state_d == GNT1) && bus.req1);
    end

    // All state in one register bank; reset forces everything idle at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_served_q <= 1'b1;
            gnt0_q        <= 1'b0;
            gnt1_q        <= 1'b0;
            s_q           <= 1'b0;
            y_q           <= '0;
            y_valid_q     <= 1'b0;
`ifdef MUX_ARB_HOLD_LIMIT_EN
            hold_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            gnt0_q        <= gnt0_d;
            gnt1_q        <= gnt1_d;
            s_q           <= s_d;
            y_q           <= y_d;
            y_valid_q     <= y_valid_d;
`ifdef MUX_ARB_HOLD_LIMIT_EN
            hold_q        <= hold_d;
`endif
        end
    end

    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.s       = s_q;
    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign state_dbg   = state_q;

`ifdef MUX_ARB_HOLD_LIMIT_EN
    assign hold_dbg = hold_q;
`else
    assign hold_dbg = '0;
`endif

endmodule

// File: tb/tb_mux_arbiter2.sv
// Testbench for mux_arbiter2: directed scenarios plus randomized traffic
// against an ownership/run-length model of the arbitration rules.
module tb_mux_arbiter2;

    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;
`ifdef MUX_ARB_HOLD_LIMIT_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic                        clk;
    logic                        rst_n;
    logic [1:0]                  state_dbg;
    logic [$clog2(MAX_HOLD)-1:0] hold_dbg;

    mux_arbiter2_if #(.WIDTH(WIDTH)) bus ();

    mux_arbiter2 #(
        .WIDTH   (WIDTH),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .state_dbg(state_dbg),
        .hold_dbg (hold_dbg)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the mux (-1 none), who was served last,
    // and how many consecutive cycles the current owner has held it.
    int               m_owner;
    int               m_last;
    int               m_run;
    logic             m_s;
    logic [WIDTH-1:0] m_y;
    logic             m_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 1;
        m_run   = 0;
        m_s     = 1'b0;
        m_y     = '0;
        m_v     = 1'b0;
    endtask

    // Apply the arbitration rules for one rising edge using current inputs.
    task automatic model_edge();
        bit r[2];
        int nxt;
        r[0] = bus.req0;
        r[1] = bus.req1;
        if (m_owner < 0) begin
            if (r[0] && r[1]) nxt = 1 - m_last;
            else if (r[0])    nxt = 0;
            else if (r[1])    nxt = 1;
            else              nxt = -1;
        end else if (!r[m_owner]) begin
            nxt = r[1 - m_owner] ? 1 - m_owner : -1;
        end else if (HOLD_EN && m_run >= MAX_HOLD && r[1 - m_owner]) begin
            nxt = 1 - m_owner;
        end else begin
            nxt = m_owner;
        end

        if (nxt < 0) begin
            m_run = 0;
        end else if (nxt != m_owner) begin
            m_run  = 1;
            m_last = nxt;
        end else begin
            m_run++;
        end

        if (nxt >= 0) m_s = (nxt == 1);
        m_y     = m_s ? bus.b : bus.a;
        m_v     = (nxt >= 0) && r[nxt];
        m_owner = nxt;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_gnt0"}, 32'(bus.gnt0), 32'(m_owner == 0));
        chk({tag, "_gnt1"}, 32'(bus.gnt1), 32'(m_owner == 1));
        chk({tag, "_s"}, 32'(bus.s), 32'(m_s));
        chk({tag, "_y"}, 32'(bus.y), 32'(m_y));
        chk({tag, "_yv"}, 32'(bus.y_valid), 32'(m_v));
    endtask

    // Driver tasks
    task automatic drive(input logic r0, input logic [WIDTH-1:0] da,
                         input logic r1, input logic [WIDTH-1:0] db);
        bus.req0 = r0;
        bus.a    = da;
        bus.req1 = r1;
        bus.b    = db;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    // Reset asserted between edges, checked immediately, released on negedge.
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, '0);
        model_reset();
        #3;
        check_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Single request from reset: grant, data and valid after one edge.
        drive(1'b1, 8'hA5, 1'b0, 8'h3C);
        tick("r27");
        chk("r27_gnt0_const", 32'(bus.gnt0), 32'd1);
        chk("r27_y_const", 32'(bus.y), 32'hA5);
        chk("r27_s_const", 32'(bus.s), 32'd0);

        // Tie after reset goes to requester 0, then direct handover to 1.
        async_reset("r28_rst");
        drive(1'b1, 8'h11, 1'b1, 8'h22);
        tick("r28_tie");
        chk("r28_tie_gnt0_const", 32'(bus.gnt0), 32'd1);
        drive(1'b0, 8'h33, 1'b1, 8'h44);
        tick("r28_hand");
        chk("r28_hand_gnt1_const", 32'(bus.gnt1), 32'd1);
        chk("r28_hand_y_const", 32'(bus.y), 32'h44);

        // Hold GNT1, release all, then a tie must go back to requester 0.
        drive(1'b0, 8'h55, 1'b1, 8'h66);
        tick("r29_hold");
        drive(1'b0, 8'h77, 1'b0, 8'h88);
        tick("r29_idle");
        chk("r29_idle_s_const", 32'(bus.s), 32'd1);
        chk("r29_idle_yv_const", 32'(bus.y_valid), 32'd0);
        chk("r29_idle_y_const", 32'(bus.y), 32'h88);
        drive(1'b1, 8'h99, 1'b1, 8'hAA);
        tick("r29_tie");
        chk("r29_tie_gnt0_const", 32'(bus.gnt0), 32'd1);

        // Both requests held high from idle: alternate every MAX_HOLD cycles
        // with the hold limit, otherwise requester 0 keeps the grant.
        async_reset("r30_rst");
        for (int i = 0; i < 3 * MAX_HOLD; i++) begin
            drive(1'b1, 8'(i), 1'b1, 8'(8'h80 + i));
            tick("r30");
            chk("r30_gnt0_pattern", 32'(bus.gnt0),
                32'(HOLD_EN ? (((i / MAX_HOLD) % 2) == 0) : 1'b1));
        end

        // Reset in the middle of a GNT1 grant, then tie goes to requester 0.
        async_reset("r31_pre");
        drive(1'b0, 8'h01, 1'b1, 8'h02);
        tick("r31_g1");
        tick("r31_g1b");
        async_reset("r31_mid");
        chk("r31_mid_gnt1_const", 32'(bus.gnt1), 32'd0);
        drive(1'b1, 8'h03, 1'b1, 8'h04);
        tick("r31_tie");
        chk("r31_tie_gnt0_const", 32'(bus.gnt0), 32'd1);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 8'($urandom),
                  1'($urandom_range(0, 3) != 0), 8'($urandom));
            tick("rand");
            if ($urandom_range(0, 59) == 0) begin
                async_reset("rand_rst");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
